// File: rtl/hidden_cpu_pkg.sv
// Shared opcode/state types and field widths
// for the hidden_cpu accumulator core.
package hidden_cpu_pkg;

  localparam int OPC_W  = 3;
  localparam int OPND_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 3'b000,
    OP_SHI = 3'b001,
    OP_ST  = 3'b010,
    OP_LD  = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_MUL = 3'b110,
    OP_OUT = 3'b111
  } opcode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/hidden_cpu_mul.sv
// Fixed-latency shift-add multiplier: DATA_W edges
// after start, done is high with the low product on result.
module hidden_cpu_mul #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_p;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic [DATA_W-1:0] w_sum;

  assign w_sum  = r_p + (r_b[0] ? r_a : '0);
  assign done   = r_busy && (r_cnt == CNT_W'(1));
  assign result = w_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_a    <= a;
      r_b    <= b;
      r_p    <= '0;
      r_cnt  <= CNT_W'(DATA_W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      // one multiplier bit per edge, zero bits included
      r_p   <= w_sum;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - CNT_W'(1);
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/hidden_cpu_param.sv
// Parametrised accumulator core: 8 opcodes, flop
// register file, multi-cycle MUL with ready backpressure.
module hidden_cpu_param
  import hidden_cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] out_bus,
  output logic              carry
);

  localparam int IDX_W = $clog2(NUM_REGS);

  if (DATA_W < 4 || DATA_W > 16) begin : g_bad_dw
    $error("hidden_cpu_param: DATA_W must be 4..16");
  end
  if (NUM_REGS != 2 && NUM_REGS != 4 && NUM_REGS != 8) begin : g_bad_nr
    $error("hidden_cpu_param: NUM_REGS must be 2, 4 or 8");
  end

  state_t            r_state;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_out;
  logic              r_carry;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  opcode_t           w_op;
  logic [OPND_W-1:0] w_opnd;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rv;
  logic              w_acc;
  logic              w_mul_start;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_res;

  assign w_op        = opcode_t'(instruction[5:3]);
  assign w_opnd      = instruction[OPND_W-1:0];
  assign w_idx       = w_opnd[IDX_W-1:0];
  assign w_rv        = r_regs[w_idx];
  assign instr_ready = (r_state == S_IDLE);
  assign w_acc       = instr_valid && instr_ready;
  assign w_mul_start = w_acc && (w_op == OP_MUL);
  assign out_bus     = r_out;
  assign carry       = r_carry;

  hidden_cpu_mul #(.DATA_W(DATA_W)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (w_mul_start),
    .a      (r_acc),
    .b      (w_rv),
    .done   (w_mul_done),
    .result (w_mul_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_out   <= '0;
      r_carry <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_acc) begin
          unique case (w_op)
            OP_NOP: ;
            OP_SHI: r_acc <= {r_acc[DATA_W-4:0], w_opnd};
            OP_ST:  r_regs[w_idx] <= r_acc;
            OP_LD:  r_acc <= w_rv;
            OP_ADD: {r_carry, r_acc} <= {1'b0, r_acc} + {1'b0, w_rv};
            OP_SUB: begin
              r_acc   <= r_acc - w_rv;
              r_carry <= (r_acc < w_rv);
            end
            OP_MUL: r_state <= S_MUL;
            OP_OUT: r_out <= r_acc;
          endcase
        end
        S_MUL: if (w_mul_done) begin
          r_acc   <= w_mul_res;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_cpu_param.sv
// Directed + random bench for hidden_cpu_param against
// an arithmetic reference model (DATA_W=8, NUM_REGS=4).
module tb_hidden_cpu_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] instruction = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] out_bus;
  logic       carry;

  int n_vec = 0;
  int n_err = 0;

  int m_acc, m_out, m_carry, m_busy, m_pend;
  int m_regs [4];

  hidden_cpu_param #(.DATA_W(8), .NUM_REGS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .out_bus     (out_bus),
    .carry       (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_out = 0; m_carry = 0; m_busy = 0; m_pend = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
  endtask

  task automatic model_edge(input logic v, input logic [5:0] ins);
    int op, opnd, r, s;
    op   = int'(ins[5:3]);
    opnd = int'(ins[2:0]);
    r    = m_regs[opnd % 4];
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_acc = m_pend;
    end else if (v) begin
      case (op)
        1: m_acc = (m_acc * 8 + opnd) % 256;
        2: m_regs[opnd % 4] = m_acc;
        3: m_acc = r;
        4: begin
          s = m_acc + r;
          m_carry = (s > 255) ? 1 : 0;
          m_acc = s % 256;
        end
        5: begin
          m_carry = (m_acc < r) ? 1 : 0;
          m_acc = (m_acc - r + 256) % 256;
        end
        6: begin
          m_pend = (m_acc * r) % 256;
          m_busy = 8;
        end
        7: m_out = m_acc;
        default: ;
      endcase
    end
  endtask

  task automatic tick(input logic v, input logic [5:0] ins);
    instruction = ins;
    instr_valid = v;
    @(posedge clk);
    model_edge(v, ins);
    #1;
    chk("ready", 16'(instr_ready), 16'(m_busy == 0));
    chk("out_bus", 16'(out_bus), 16'(m_out));
    chk("carry", 16'(carry), 16'(m_carry));
  endtask

  function automatic logic [5:0] mk(input int op, input int opnd);
    logic [2:0] o, d;
    o = 3'(op);
    d = 3'(opnd);
    return {o, d};
  endfunction

  task automatic set_acc(input int v);
    tick(1'b1, mk(1, (v >> 6) & 3));
    tick(1'b1, mk(1, (v >> 3) & 7));
    tick(1'b1, mk(1, v & 7));
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_out", 16'(out_bus), 16'h00);
    chk("rst_carry", 16'(carry), 16'h0);
    chk("rst_ready", 16'(instr_ready), 16'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int cnt;
    logic v;
    model_reset();

    do_reset();
    tick(1'b1, mk(7, 0));
    chk("r33_out", 16'(out_bus), 16'h00);

    tick(1'b1, mk(1, 5));
    tick(1'b1, mk(1, 3));
    tick(1'b1, mk(7, 0));
    chk("r34_out", 16'(out_bus), 16'h2B);

    set_acc(8'h80);
    tick(1'b1, mk(2, 1));
    tick(1'b1, mk(4, 1));
    chk("r35_add_c", 16'(carry), 16'h1);
    tick(1'b1, mk(7, 0));
    chk("r35_add_acc", 16'(out_bus), 16'h00);
    tick(1'b1, mk(3, 1));
    tick(1'b1, mk(5, 1));
    tick(1'b1, mk(7, 0));
    chk("r35_sub_acc", 16'(out_bus), 16'h00);
    chk("r35_sub_c", 16'(carry), 16'h0);

    set_acc(8'h05);
    tick(1'b1, mk(2, 2));
    set_acc(8'h03);
    tick(1'b1, mk(5, 2));
    tick(1'b1, mk(7, 0));
    chk("r36_out", 16'(out_bus), 16'hFE);
    chk("r36_c", 16'(carry), 16'h1);

    set_acc(8'h0B);
    tick(1'b1, mk(2, 7));
    set_acc(8'h0C);
    tick(1'b1, mk(6, 3));
    cnt = 0;
    while (instr_ready === 1'b0 && cnt < 20) begin
      cnt++;
      tick(1'b1, mk(4, 3));
    end
    chk("r37_lat", 16'(cnt), 16'd8);
    tick(1'b1, mk(7, 0));
    chk("r37_mul", 16'(out_bus), 16'h84);
    tick(1'b1, mk(4, 3));
    tick(1'b1, mk(7, 0));
    chk("r37_add", 16'(out_bus), 16'h8F);

    set_acc(8'h00);
    tick(1'b1, mk(6, 1));
    cnt = 0;
    while (instr_ready === 1'b0 && cnt < 20) begin
      cnt++;
      tick(1'b0, mk(0, 0));
    end
    chk("mul_zero_lat", 16'(cnt), 16'd8);

    do_reset();
    set_acc(8'h0B);
    tick(1'b1, mk(2, 3));
    set_acc(8'h0C);
    tick(1'b1, mk(6, 3));
    repeat (3) tick(1'b0, mk(0, 0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("r38_ready", 16'(instr_ready), 16'h1);
    chk("r38_out", 16'(out_bus), 16'h00);
    @(negedge clk);
    rst = 1'b1;
    tick(1'b1, mk(7, 0));
    chk("r38_acc", 16'(out_bus), 16'h00);
    repeat (10) tick(1'b0, mk(0, 0));

    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 3) != 0);
      tick(v, 6'($urandom_range(0, 63)));
    end
    tick(1'b1, mk(0, 0));
    repeat (10) tick(1'b1, mk(7, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hidden_cpu_param.md
HIDDEN_CPU_PARAM -- requirements
Module: hidden_cpu_param

Interface
REQ-001 Parameter DATA_W, default 8, meaning accumulator/register/output width; the legal range SHALL be 4..16.
REQ-002 Parameter NUM_REGS, default 4, meaning general register count; the legal values SHALL be 2, 4 and 8.
REQ-003 Port clk  input  1  meaning the single clock; all state SHALL be rising-edge triggered.
REQ-004 Port rst  input  1  meaning reset, asynchronous and active-low.
REQ-005 Port instruction  input  6  meaning opcode[5:3] and operand[2:0].
REQ-006 Port instr_valid  input  1  meaning an instruction is presented.
REQ-007 Port instr_ready  output  1  meaning the core accepts an instruction this cycle.
REQ-008 Port out_bus  output  DATA_W  meaning the registered output latch.
REQ-009 Port carry  output  1  meaning the carry/borrow flag.

Function
REQ-010 An instruction SHALL be accepted on a rising edge where instr_valid=1 and instr_ready=1; with any other combination the instruction SHALL be ignored, with no side effects.
REQ-011 The register index SHALL be operand[$clog2(NUM_REGS)-1:0]; higher operand bits SHALL be ignored for register ops.
REQ-012 000 NOP: no state change.
REQ-013 001 SHI: acc <= {acc[DATA_W-4:0], operand} (immediate shift-in); carry unchanged.
REQ-014 010 ST: reg[idx] <= acc.
REQ-015 011 LD: acc <= reg[idx].
REQ-016 100 ADD: {carry, acc} <= acc + reg[idx], computed DATA_W+1 wide.
REQ-017 101 SUB: acc <= acc - reg[idx] mod 2^DATA_W; carry <= 1 iff acc < reg[idx] (borrow).
REQ-018 110 MUL: acc <= low DATA_W bits of acc*reg[idx], computed by iterative shift-add; carry unchanged.
REQ-019 111 OUT: out_bus <= acc.
REQ-020 All opcodes except MUL SHALL complete at the accepting edge; instr_ready SHALL stay 1.
REQ-021 FSM states SHALL be IDLE and MUL; IDLE->MUL on MUL acceptance; MUL->IDLE after exactly DATA_W further edges, with acc written on the last of them.
REQ-022 MUL latency SHALL be fixed at DATA_W cycles regardless of operand values (including zero).
REQ-023 instr_ready SHALL be 0 in state MUL and 1 in IDLE, driven from registered state only.
REQ-024 The multiplicand and multiplier SHALL be captured at acceptance, so that ST/LD semantics are unaffected by later register contents.
REQ-025 Instructions presented while instr_ready=0 SHALL be dropped rather than queued; the source holds or re-presents them.
REQ-026 Arithmetic SHALL wrap modulo 2^DATA_W; no saturation.

Reset
REQ-027 While rst=0: acc, all registers and out_bus SHALL be 0, carry=0, state=IDLE, instr_ready=1.
REQ-028 Reset asserted mid-MUL SHALL abort the multiply immediately, with no partial result written.
REQ-029 The first instruction SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-030 Package hidden_cpu_pkg SHALL hold the opcode enum, the FSM state enum and the operand field width constant.
REQ-031 The multiply SHALL be a sub-module hidden_cpu_mul, parametrised by DATA_W, with start/done and a result port.
REQ-032 The register file SHALL be a flop array inside hidden_cpu_param; no memories.

Verification (DATA_W=8, NUM_REGS=4)
REQ-033 Reset: hold rst=0 -> out_bus=0x00, carry=0, instr_ready=1; release rst, then OUT -> out_bus stays 0x00.
REQ-034 SHI 5, SHI 3, OUT -> out_bus=0x2B on the OUT edge.
REQ-035 acc=0x80, ST r1, ADD r1 -> acc=0x00, carry=1; then LD r1, SUB r1 -> acc=0x00, carry=0.
REQ-036 acc=0x03, r2=0x05, SUB r2, OUT -> out_bus=0xFE, carry=1.
REQ-037 acc=0x0C, r3=0x0B, MUL r3 with instr_valid held at ADD r3 -> instr_ready=0 for 8 cycles, then acc=0x84; the held ADD is accepted only after that, giving acc=0x8F.
REQ-038 Assert rst at MUL cycle 4 -> acc=0x00, instr_ready=1, and out_bus unchanged at 0x00.
